// File: rtl/fib_ovf_gen_if.sv
// fib_ovf_gen_if: start/index request and result bundle for the Fibonacci engine
//   i_start  start request, honoured only while o_ready=1
//   i_n      Fibonacci index, sampled on the accepting edge
//   o_ready  engine idle, can accept i_start
//   o_done   one-cycle pulse, o_fib/o_ovf updated this cycle
//   o_ovf    result exceeded MAX_VAL, o_fib saturated
//   o_fib    fib(n) or MAX_VAL on overflow
interface fib_ovf_gen_if #(
    parameter int N_W = 8,
    parameter int W   = 20
);
    logic           i_start;
    logic [N_W-1:0] i_n;
    logic           o_ready;
    logic           o_done;
    logic           o_ovf;
    logic [W-1:0]   o_fib;

    modport master (output i_start, i_n, input o_ready, o_done, o_ovf, o_fib);
    modport slave  (input i_start, i_n, output o_ready, o_done, o_ovf, o_fib);
endinterface

// File: rtl/fib_ovf_gen.sv
// fib_ovf_gen: iterative fib(n) engine saturating to MAX_VAL with overflow flag
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    fib_ovf_gen_if slave: i_start/i_n in, o_ready/o_done/o_ovf/o_fib out
module fib_ovf_gen #(
    parameter int N_W     = 8,
    parameter int W       = 20,
    parameter int MAX_VAL = 9999
) (
    input logic           i_clk,
    input logic           i_rst,
    fib_ovf_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

    state_t         state;
    logic [W-1:0]   t0, t1, fib;
    logic [N_W-1:0] cnt;
    logic           ovf;

    assign bus.o_ready = state == IDLE;
    assign bus.o_done  = state == DONE;
    assign bus.o_fib   = fib;
    assign bus.o_ovf   = ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            t0    <= '0;
            t1    <= '0;
            cnt   <= '0;
            fib   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_start) begin
                    t0    <= '0;
                    t1    <= W'(1);
                    cnt   <= bus.i_n;
                    state <= OP;
                end
                // overflow wins over cnt==0 so large n exits early at a fixed latency
                OP: if (t0 > MAX_W) begin
                    fib   <= MAX_W;
                    ovf   <= 1'b1;
                    state <= DONE;
                end else if (cnt == '0) begin
                    fib   <= t0;
                    ovf   <= 1'b0;
                    state <= DONE;
                end else begin
                    t0  <= t1;
                    t1  <= t0 + t1;
                    cnt <= cnt - N_W'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_ovf_gen.sv
// tb_fib_ovf_gen: directed scoreboard bench for fib_ovf_gen
module tb_fib_ovf_gen;
    localparam int N_W = 8, W = 20, MAX_VAL = 9999;

    typedef struct {
        int fib;
        int ovf;
        int lat;
    } exp_t;

    logic clk = 0, rst = 1;
    int   edge_cnt = 0;
    int   n_pass = 0, n_total = 0;
    exp_t sb[$];

    fib_ovf_gen_if #(.N_W(N_W), .W(W)) bus ();
    fib_ovf_gen #(.N_W(N_W), .W(W), .MAX_VAL(MAX_VAL)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input int n);
        exp_t r;
        int a = 0, b = 1, s;
        for (int j = 0; ; j++) begin
            if (a > MAX_VAL) begin
                r.fib = MAX_VAL; r.ovf = 1; r.lat = j + 1;
                return r;
            end
            if (j == n) begin
                r.fib = a; r.ovf = 0; r.lat = j + 1;
                return r;
            end
            s = a + b; a = b; b = s;
        end
    endfunction

    // called at a negedge with the engine idle; returns at the first idle negedge after DONE
    task automatic run(input int n, input bit noisy);
        exp_t e;
        int   e0, extra;
        bit   got = 0;
        bus.i_start = 1;
        bus.i_n = N_W'(n);
        sb.push_back(model(n));
        @(negedge clk);
        e0 = edge_cnt;
        bus.i_start = 0;
        check($sformatf("ready_busy n=%0d", n), 32'(bus.o_ready), 0);
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.o_done) got = 1;
            else begin
                if (noisy) begin
                    bus.i_start = 1'($urandom);
                    bus.i_n = N_W'($urandom);
                end
                @(negedge clk);
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check($sformatf("done_timeout n=%0d", n), 0, 1);
            return;
        end
        check($sformatf("latency n=%0d", n), 32'(edge_cnt - e0), 32'(e.lat));
        check($sformatf("fib n=%0d", n), 32'(bus.o_fib), 32'(e.fib));
        check($sformatf("ovf n=%0d", n), 32'(bus.o_ovf), 32'(e.ovf));
        if (noisy) begin
            bus.i_start = 1;
            bus.i_n = N_W'(3);
        end
        @(negedge clk);
        bus.i_start = 0;
        check($sformatf("done_one_cycle n=%0d", n), 32'(bus.o_done), 0);
        check($sformatf("ready_back n=%0d", n), 32'(bus.o_ready), 1);
        if (noisy) begin
            extra = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                extra += int'(bus.o_done);
            end
            check("noisy_extra_done", 32'(extra), 0);
            check("noisy_ready_stays", 32'(bus.o_ready), 1);
        end
    endtask

    initial begin
        int e0, dones;
        bus.i_start = 0;
        bus.i_n = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 1);
        check("rst_done", 32'(bus.o_done), 0);
        check("rst_fib", 32'(bus.o_fib), 0);
        check("rst_ovf", 32'(bus.o_ovf), 0);
        rst = 0;
        @(negedge clk);
        run(0, 0);
        run(1, 0);
        run(2, 0);
        run(10, 0);
        check("fib20_const", 32'(model(20).fib), 32'h1A6D);
        run(20, 0);
        run(21, 0);
        run(99, 0);
        run(10, 1);
        run(7, 0);
        bus.i_start = 1;
        bus.i_n = N_W'(15);
        @(negedge clk);
        e0 = edge_cnt;
        bus.i_start = 0;
        dones = 0;
        while (edge_cnt < e0 + 4) begin
            @(negedge clk);
            dones += int'(bus.o_done);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_ready", 32'(bus.o_ready), 1);
        check("midrst_fib", 32'(bus.o_fib), 0);
        check("midrst_ovf", 32'(bus.o_ovf), 0);
        check("midrst_done", 32'(bus.o_done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dones += int'(bus.o_done);
        end
        check("midrst_no_done", 32'(dones), 0);
        run(5, 0);
        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
